// File: rtl/axi_lite_lut_reader.sv
// AXI4-lite read-master front end for a memory-resident 2W-bit lookup table,
// with a single-entry last-result cache in front of the bus.
module axi_lite_lut_reader #(
    parameter int unsigned W         = 3,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter bit          CACHE_EN  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [W-1:0]     req_a,
    input  logic [W-1:0]     req_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [2*W-1:0]   resp_data,
    output logic             resp_err,
    input  logic             cache_flush,
    input  logic             mem_busy,
    output logic [15:0]      txn_count,
    output logic [31:0]      m_axi_araddr,
    output logic             m_axi_arvalid,
    input  logic             m_axi_arready,
    input  logic [31:0]      m_axi_rdata,
    input  logic [1:0]       m_axi_rresp,
    input  logic             m_axi_rvalid,
    output logic             m_axi_rready,
    output logic [1:0]       dbg_state
);
    // All channels use valid/ready: a transfer happens on a rising edge where both
    // are high; a source keeps valid and its payload stable until that edge.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       araddr_q, araddr_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [2*W-1:0]    resp_data_q, resp_data_d;
    logic [15:0]       txn_q, txn_d;
    logic              cache_valid_q, cache_valid_d;
    logic [2*W-1:0]    cache_tag_q, cache_tag_d;
    logic [2*W-1:0]    cache_val_q, cache_val_d;
    logic [2*W-1:0]    pend_tag_q, pend_tag_d;
    logic [2*W-1:0]    req_key;
    logic              accept;
    logic              hit;
    logic              unused_bits;

    assign req_key     = {req_a, req_b};
    assign req_ready   = (state_q == S_IDLE) && !mem_busy && rst;
    assign accept      = req_valid && req_ready;
    // Lookup sees the registered valid, so a flush arriving with the request still hits.
    assign hit         = CACHE_EN && cache_valid_q && (req_key == cache_tag_q);
    assign unused_bits = ^{m_axi_rdata[31:2*W], m_axi_rresp[0]};

    assign m_axi_araddr  = araddr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_data     = resp_data_q;
    assign resp_err      = resp_err_q;
    assign txn_count     = txn_q;
    assign dbg_state     = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            araddr_q      <= '0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_err_q    <= 1'b0;
            resp_data_q   <= '0;
            txn_q         <= '0;
            cache_valid_q <= 1'b0;
            cache_tag_q   <= '0;
            cache_val_q   <= '0;
            pend_tag_q    <= '0;
        end else begin
            state_q       <= state_d;
            araddr_q      <= araddr_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            resp_valid_q  <= resp_valid_d;
            resp_err_q    <= resp_err_d;
            resp_data_q   <= resp_data_d;
            txn_q         <= txn_d;
            cache_valid_q <= cache_valid_d;
            cache_tag_q   <= cache_tag_d;
            cache_val_q   <= cache_val_d;
            pend_tag_q    <= pend_tag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = hit ? S_RESP : S_ADDR;
            S_ADDR:  if (m_axi_arready) state_d = S_DATA;
            S_DATA:  if (m_axi_rvalid) state_d = S_RESP;
            S_RESP:  if (resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        araddr_d      = araddr_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        resp_valid_d  = resp_valid_q;
        resp_err_d    = resp_err_q;
        resp_data_d   = resp_data_q;
        txn_d         = txn_q;
        cache_valid_d = cache_valid_q;
        cache_tag_d   = cache_tag_q;
        cache_val_d   = cache_val_q;
        pend_tag_d    = pend_tag_q;
        case (state_q)
            S_IDLE: begin
                if (accept && hit) begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = cache_val_q;
                    resp_err_d   = 1'b0;
                end else if (accept) begin
                    araddr_d   = BASE_ADDR + {{(30-2*W){1'b0}}, req_key, 2'b00};
                    arvalid_d  = 1'b1;
                    pend_tag_d = req_key;
                    txn_d      = txn_q + 16'd1;
                end
            end
            S_ADDR: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            S_DATA: begin
                if (m_axi_rvalid) begin
                    rready_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_data_d  = m_axi_rdata[2*W-1:0];
                    resp_err_d   = m_axi_rresp[1];
                    if (m_axi_rresp[1]) begin
                        cache_valid_d = 1'b0;
                    end else begin
                        cache_valid_d = 1'b1;
                        cache_tag_d   = pend_tag_q;
                        cache_val_d   = m_axi_rdata[2*W-1:0];
                    end
                end
            end
            S_RESP: begin
                if (resp_ready) resp_valid_d = 1'b0;
            end
            default: ;
        endcase
        // Flush is applied last so it overrides a fill landing in the same cycle.
        if (cache_flush) cache_valid_d = 1'b0;
    end
endmodule
